// File: rtl/fp_div_seq.sv
`timescale 1ns/1ps
// fp_div_seq: iterative IEEE-754-style divider (one quotient bit per cycle) with
// RNE rounding, subnormals, special values, exception flags and optional saturation.
module fp_div_seq #(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int SAT_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] data_dividend,
  input  logic [EXP_W+MAN_W:0] data_divisor,
  input  logic                 input_valid,
  output logic [EXP_W+MAN_W:0] data_q,
  output logic [4:0]           flags,
  output logic                 output_update,
  output logic                 idle
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 3;
  localparam int MW   = MAN_W + 1;
  localparam int QW   = MAN_W + 3;
  localparam int CW   = $clog2(QW);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);
  localparam logic [CW-1:0]        LAST_BIT = CW'(QW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_DIV, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t                state;
  logic [W-1:0]          a_reg, b_reg;
  logic signed [EW-1:0]  exp_r;
  logic [MAN_W+1:0]      rem;
  logic [MAN_W:0]        den;
  logic [QW-1:0]         quo;
  logic [CW-1:0]         cnt;
  logic                  sticky_r, tiny_r;
  logic [W-1:0]          res_q;
  logic [4:0]            res_flags;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_zero, a_sub, a_inf, a_nan;
  logic b_zero, b_sub, b_inf, b_nan;
  logic sgn;
  logic [W-1:0] inf_v, maxf_v, zero_v, qnan_v, ovf_v;

  assign a_exp  = a_reg[W-2:MAN_W];
  assign b_exp  = b_reg[W-2:MAN_W];
  assign a_man  = a_reg[MAN_W-1:0];
  assign b_man  = b_reg[MAN_W-1:0];
  assign a_zero = (~|a_exp) & (~|a_man);
  assign a_sub  = (~|a_exp) & (|a_man);
  assign a_inf  = (&a_exp) & (~|a_man);
  assign a_nan  = (&a_exp) & (|a_man);
  assign b_zero = (~|b_exp) & (~|b_man);
  assign b_sub  = (~|b_exp) & (|b_man);
  assign b_inf  = (&b_exp) & (~|b_man);
  assign b_nan  = (&b_exp) & (|b_man);
  assign sgn    = a_reg[W-1] ^ b_reg[W-1];
  assign inf_v  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign maxf_v = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  assign zero_v = {sgn, {(W-1){1'b0}}};
  assign qnan_v = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  assign ovf_v  = (SAT_MODE != 0) ? maxf_v : inf_v;

  // Subnormals are brought to 1.x form; the shift is the distance from the
  // highest set mantissa bit up to the hidden-bit position.
  int                   a_shift, b_shift;
  logic [MAN_W:0]       a_mn, b_mn;
  logic signed [EW-1:0] a_en, b_en, e_calc;

  always_comb begin
    a_shift = 0;
    b_shift = 0;
    for (int i = 0; i < MAN_W; i++) begin
      if (a_man[i]) a_shift = MAN_W - i;
      if (b_man[i]) b_shift = MAN_W - i;
    end
    a_mn   = a_sub ? MW'({1'b0, a_man} << a_shift) : {1'b1, a_man};
    b_mn   = b_sub ? MW'({1'b0, b_man} << b_shift) : {1'b1, b_man};
    a_en   = a_sub ? EW'(1 - a_shift) : EW'(a_exp);
    b_en   = b_sub ? EW'(1 - b_shift) : EW'(b_exp);
    e_calc = a_en - b_en + E_BIAS;
  end

  logic         is_special;
  logic [W-1:0] spec_q;
  logic [4:0]   spec_flags;

  always_comb begin
    is_special = 1'b1;
    spec_q     = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_q = qnan_v;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q     = qnan_v;
      spec_flags = 5'b10000;
    end else if (a_inf) begin
      spec_q = inf_v;
    end else if (b_inf || a_zero) begin
      spec_q = zero_v;
    end else if (b_zero) begin
      spec_q     = (SAT_MODE != 0) ? maxf_v : inf_v;
      spec_flags = 5'b01000;
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalisation: bring q into [1,2), then denormalise tiny results so the
  // shifted-out bits survive only as sticky.
  logic [QW-1:0]        q1, q2;
  logic signed [EW-1:0] e1, sh;
  int                   sh_i;
  logic                 st2, tiny;

  always_comb begin
    q1   = quo[QW-1] ? quo : {quo[QW-2:0], 1'b0};
    e1   = quo[QW-1] ? exp_r : exp_r - E_ONE;
    q2   = q1;
    st2  = (rem != '0);
    tiny = 1'b0;
    sh   = E_ONE - e1;
    sh_i = int'(sh);
    if (e1 < E_ONE) begin
      tiny = 1'b1;
      if (sh_i >= QW) begin
        q2  = '0;
        st2 = 1'b1;
      end else begin
        q2  = q1 >> sh_i;
        st2 = st2 | (|(q1 & ~({QW{1'b1}} << sh_i)));
      end
    end
  end

  logic [MAN_W:0]       mant;
  logic                 g, r, inexact, inc, ovf;
  logic [MAN_W+1:0]     rnd;
  logic signed [EW-1:0] e_out;
  logic [MAN_W-1:0]     man_out;

  always_comb begin
    mant    = quo[QW-1:2];
    g       = quo[1];
    r       = quo[0];
    inexact = g | r | sticky_r;
    inc     = g & (r | sticky_r | mant[0]);
    rnd     = {1'b0, mant} + {{MW{1'b0}}, inc};
    man_out = rnd[MAN_W-1:0];
    e_out   = exp_r;
    if (exp_r == E_ZERO) begin
      if (rnd[MAN_W]) e_out = E_ONE;
    end else if (rnd[MAN_W+1]) begin
      e_out   = exp_r + E_ONE;
      man_out = rnd[MAN_W:1];
    end
    ovf = (e_out >= E_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idle          <= 1'b1;
      output_update <= 1'b0;
      data_q        <= '0;
      flags         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      exp_r         <= '0;
      rem           <= '0;
      den           <= '0;
      quo           <= '0;
      cnt           <= '0;
      sticky_r      <= 1'b0;
      tiny_r        <= 1'b0;
      res_q         <= '0;
      res_flags     <= '0;
    end else begin
      output_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (input_valid) begin
            a_reg <= data_dividend;
            b_reg <= data_divisor;
            idle  <= 1'b0;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (is_special) begin
            res_q     <= spec_q;
            res_flags <= spec_flags;
            state     <= S_OUT;
          end else begin
            exp_r <= e_calc;
            rem   <= {1'b0, a_mn};
            den   <= b_mn;
            quo   <= '0;
            cnt   <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          if (rem >= {1'b0, den}) begin
            rem <= (rem - {1'b0, den}) << 1;
            quo <= {quo[QW-2:0], 1'b1};
          end else begin
            rem <= rem << 1;
            quo <= {quo[QW-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) state <= S_NORM;
        end
        S_NORM: begin
          quo      <= q2;
          sticky_r <= st2;
          tiny_r   <= tiny;
          exp_r    <= tiny ? E_ZERO : e1;
          state    <= S_ROUND;
        end
        S_ROUND: begin
          res_q     <= ovf ? ovf_v : {sgn, e_out[EXP_W-1:0], man_out};
          res_flags <= {1'b0, 1'b0, ovf, tiny_r & inexact, inexact | ovf};
          state     <= S_OUT;
        end
        S_OUT: begin
          data_q        <= res_q;
          flags         <= res_flags;
          output_update <= 1'b1;
          idle          <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
`timescale 1ns/1ps
// tb_fp_div_seq: directed vectors against FP16 (plain and saturating) and
// bfloat16 instances sharing one stimulus bus.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_dividend = '0;
  logic [15:0] data_divisor = '0;
  logic        input_valid = 1'b0;

  logic [15:0] q0, q1, q2;
  logic [4:0]  f0, f1, f2;
  logic        u0, u1, u2;
  logic        i0, i1, i2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.EXP_W(5), .MAN_W(10), .SAT_MODE(0)) dut (
    .clk(clk), .rst(rst), .data_dividend(data_dividend), .data_divisor(data_divisor),
    .input_valid(input_valid), .data_q(q0), .flags(f0), .output_update(u0), .idle(i0));

  fp_div_seq #(.EXP_W(5), .MAN_W(10), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst(rst), .data_dividend(data_dividend), .data_divisor(data_divisor),
    .input_valid(input_valid), .data_q(q1), .flags(f1), .output_update(u1), .idle(i1));

  fp_div_seq #(.EXP_W(8), .MAN_W(7), .SAT_MODE(0)) dut_bf (
    .clk(clk), .rst(rst), .data_dividend(data_dividend), .data_divisor(data_divisor),
    .input_valid(input_valid), .data_q(q2), .flags(f2), .output_update(u2), .idle(i2));

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic sample(input int which, output logic [15:0] q, output logic [4:0] f,
                        output logic u, output logic i);
    q = q0; f = f0; u = u0; i = i0;
    case (which)
      1: begin q = q1; f = f1; u = u1; i = i1; end
      2: begin q = q2; f = f2; u = u2; i = i2; end
      default: ;
    endcase
  endtask

  task automatic wait_all_idle();
    int k = 0;
    while (!(i0 && i1 && i2) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // One request: latency, busy idle, result, flags, idle at pulse, single-cycle pulse.
  task automatic apply_stimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input int which, input logic [15:0] exp_q, input logic [4:0] exp_f,
                                input int exp_lat, input bit poke);
    int edges;
    bit seen, busy_ok;
    logic [15:0] q;
    logic [4:0] f;
    logic u, i;
    wait_all_idle();
    @(negedge clk);
    data_dividend = a;
    data_divisor  = b;
    input_valid   = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    edges = 0; seen = 0; busy_ok = 1;
    u = 0; i = 0; q = '0; f = '0;
    while (!seen && edges < 40) begin
      if (poke && edges == 2) begin
        input_valid   = 1'b1;
        data_dividend = 16'h3C00;
        data_divisor  = 16'h4200;
      end
      @(posedge clk); #1;
      input_valid = 1'b0;
      edges++;
      sample(which, q, f, u, i);
      if (u) seen = 1;
      else if (i) busy_ok = 0;
    end
    check_output({tag, " latency"}, 16'(edges), 16'(exp_lat));
    check_output({tag, " q"}, q, exp_q);
    check_output({tag, " flags"}, {11'b0, f}, {11'b0, exp_f});
    check_output({tag, " idle at pulse"}, {15'b0, i}, 16'h0001);
    check_output({tag, " busy"}, {15'b0, busy_ok}, 16'h0001);
    @(posedge clk); #1;
    sample(which, q, f, u, i);
    check_output({tag, " pulse width"}, {15'b0, u}, 16'h0000);
  endtask

  initial begin
    int pulses, idle_low;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset q", q0, 16'h0000);
    check_output("reset flags", {11'b0, f0}, 16'h0000);
    check_output("reset update", {15'b0, u0}, 16'h0000);
    check_output("reset idle", {15'b0, i0}, 16'h0001);
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus("one_by_two",   16'h3C00, 16'h4000, 0, 16'h3800, 5'b00000, 17, 0);
    apply_stimulus("one_by_three", 16'h3C00, 16'h4200, 0, 16'h3555, 5'b00001, 17, 0);
    apply_stimulus("bf16_third",   16'h3F80, 16'h4040, 2, 16'h3EAB, 5'b00001, 14, 0);
    apply_stimulus("exact_sub",    16'h0400, 16'h4400, 0, 16'h0100, 5'b00000, 17, 0);
    apply_stimulus("tie_to_zero",  16'h0001, 16'h4000, 0, 16'h0000, 5'b00011, 17, 0);
    apply_stimulus("overflow_inf", 16'h7BFF, 16'h0001, 0, 16'h7C00, 5'b00101, 17, 0);
    check_output("overflow_sat q", q1, 16'h7BFF);
    check_output("overflow_sat flags", {11'b0, f1}, 16'h0005);
    apply_stimulus("div_by_zero",  16'hC000, 16'h0000, 0, 16'hFC00, 5'b01000, 2, 0);
    check_output("div_by_zero_sat q", q1, 16'hFBFF);
    apply_stimulus("zero_by_zero", 16'h0000, 16'h0000, 0, 16'h7E00, 5'b10000, 2, 0);
    apply_stimulus("inf_by_inf",   16'h7C00, 16'h7C00, 0, 16'h7E00, 5'b10000, 2, 0);
    apply_stimulus("neg_zero",     16'h8000, 16'h4000, 0, 16'h8000, 5'b00000, 2, 0);
    apply_stimulus("nan_in",       16'h7E01, 16'h3C00, 0, 16'h7E00, 5'b00000, 2, 0);
    apply_stimulus("busy_poke",    16'h4400, 16'h4000, 0, 16'h4000, 5'b00000, 17, 1);

    // Abort a division mid-flight with a simultaneous request that must lose to reset.
    wait_all_idle();
    @(negedge clk);
    data_dividend = 16'h3C00;
    data_divisor  = 16'h4200;
    input_valid   = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("busy before reset", {15'b0, i0}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    input_valid = 1'b1;
    @(posedge clk); #1;
    check_output("reset idle", {15'b0, i0}, 16'h0001);
    check_output("reset update", {15'b0, u0}, 16'h0000);
    check_output("reset q", q0, 16'h0000);
    check_output("reset flags", {11'b0, f0}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    input_valid = 1'b0;
    pulses = 0;
    idle_low = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (u0) pulses++;
      if (!i0) idle_low++;
    end
    check_output("no pulse after reset", 16'(pulses), 16'h0000);
    check_output("no accept in reset", 16'(idle_low), 16'h0000);
    apply_stimulus("after_reset", 16'h4400, 16'h4000, 0, 16'h4000, 5'b00000, 17, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Parametrised, iterative floating-point divider; the successor to the fixed FP16 divider in the same arithmetic library. It supports any IEEE-754-style format through EXP_W/MAN_W and performs full special-value handling (Inf, NaN, signed zero). It rounds round-to-nearest-even with correct subnormal handling, provides a selectable overflow mode, and outputs IEEE exception flags. It sits on the same one-request-at-a-time idle/update handshake used by the library's other multi-cycle arithmetic units.

## Interface
- EXP_W, 5: exponent field width (≥3); BIAS = 2^(EXP_W-1)-1.
- MAN_W, 10: stored mantissa width (≥2); W = 1+EXP_W+MAN_W.
- SAT_MODE, 0: 1 = overflow and divide-by-zero saturate to ±max finite; 0 = produce ±Inf.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_dividend  in  W  dividend {sign, exp, man}.
- data_divisor  in  W  divisor.
- input_valid  in  1  request; sampled only while idle=1.
- data_q  out  W  quotient; holds until the next result.
- flags  out  5  {nv, dz, of, uf, nx}; updated with data_q and held.
- output_update  out  1  one-cycle pulse when data_q/flags are new.
- idle  out  1  high when in IDLE; a request is accepted iff idle && input_valid.

## Operation
- FSM: IDLE → UNPACK → DIV → NORM → ROUND → OUT → IDLE. UNPACK goes directly to OUT for special cases.
- IDLE: if input_valid, register both operands. Inputs are ignored in every other state.
- UNPACK:
  - Classify each operand as zero, subnormal, normal, Inf, or NaN.
  - Subnormals are normalised with a leading-zero count: mantissa shifted to 1.x, exponent = 1 - shift.
  - Sign of result = XOR of operand signs.
  - Internal exponent is signed, EXP_W+3 bits: e = ex - ed + BIAS.
- Specials, in priority order:
  - Any NaN → canonical qNaN {0, all-ones exp, mantissa MSB=1, rest 0}, no flag.
  - 0/0 or Inf/Inf → qNaN, nv.
  - Inf/finite → ±Inf.
  - finite/Inf → ±0.
  - 0/nonzero → ±0.
  - nonzero finite/0 → dz; result ±Inf (SAT_MODE=0) or ±max finite (SAT_MODE=1).
- DIV: restoring division, one quotient bit per cycle, N = MAN_W+3 cycles. Produces q in (0.5, 2) with MAN_W+3 bits. Sticky = (final remainder ≠ 0).
- NORM:
  - If q < 1: shift left 1, e = e-1.
  - If e < 1 (tiny): right-shift by 1-e into the subnormal range, OR-ing shifted-out bits into sticky; shifts beyond MAN_W+2 leave only sticky. Then e = 0.
- ROUND:
  - RNE using guard/round/sticky; nx = any discarded bit nonzero.
  - Mantissa carry-out → e+1 (subnormal→min normal, or normal→next binade).
  - uf = tiny-before-rounding && nx.
  - e ≥ 2^EXP_W-1 → of and nx; result ±Inf or ±max finite per SAT_MODE.
- Zero results keep their sign (-0 allowed).

## Timing
- Reset values: data_q=0, flags=0, output_update=0, idle=1, state=IDLE.
- Accept edge = rising edge where idle && input_valid.
- Normal path: output_update is high in the cycle after the (MAN_W+7)th edge counted from accept (FP16: 17; bfloat16 EXP_W=8/MAN_W=7: 14).
- Special path: output_update is high after the 2nd edge following accept.
- idle is low from the accept edge until the OUT edge. It is high in the same cycle as output_update, so back-to-back requests are accepted with minimum spacing MAN_W+7 cycles (normal) or 2 cycles (special).
- output_update is never high for two consecutive cycles.
- rst during any state:
  - The next cycle is IDLE with idle=1, output_update=0, data_q=0, flags=0.
  - The in-flight result is discarded; no pulse is ever emitted for it.
- rst and input_valid in the same cycle: reset wins; the request is not accepted.

## Test plan
- 0x3C00/0x4000 (defaults): data_q=0x3800, flags=0. output_update is high after exactly 17 edges; idle is low for those cycles.
- 0x3C00/0x4200: data_q=0x3555, flags nx=1. With EXP_W=8, MAN_W=7: 0x3F80/0x4040 gives 0x3EAB, nx=1, latency 14.
- 0x0400/0x4400: data_q=0x0100 (exact subnormal), flags=0. 0x0001/0x4000: data_q=0x0000 (RNE tie to even), uf=1, nx=1.
- 0x7BFF/0x0001: SAT_MODE=0 gives 0x7C00; SAT_MODE=1 gives 0x7BFF; in both cases of=1, nx=1.
- Specials:
  - 0xC000/0x0000 → 0xFC00, dz=1.
  - 0x0000/0x0000 → 0x7E00, nv=1.
  - 0x7C00/0x7C00 → 0x7E00, nv=1.
  - 0x8000/0x4000 → 0x8000.
  - Each has 2-cycle latency.
- rst asserted mid-DIV: idle=1 next cycle, no output_update, data_q=0. input_valid pulsed while busy is ignored. A fresh 0x4400/0x4000 afterwards yields 0x4000.
